seq_mul_radix2: RTL and testbench

Parametrised sequential shift-add multiplier: the successor to the 4-bit combinational array multiplier in the ALU datapath. It accepts WIDTH-bit operands through a valid/ready handshake and computes one partial-product bit per cycle. It supports unsigned or two's-complement signed operation, selected per transaction. The full 2*WIDTH-bit product is held at the output until the consumer accepts it. It is used where area matters more than single-cycle latency.

---
 rtl/seq_mul_radix2.sv | 111 +++++++++++
 tb/tb_seq_mul_radix2.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_radix2.sv
// Sequential radix-2 shift-add multiplier with valid/ready handshakes.
// Signed operands are multiplied as magnitudes and the sign is applied to the final sum.
module seq_mul_radix2 #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;

  logic                 accept;
  logic                 last;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   partial;
  logic [2*WIDTH-1:0]   acc_sum;

  assign accept  = in_valid & in_ready;
  assign last    = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
  // An unsigned WIDTH-bit magnitude holds |most-negative| exactly.
  assign mag_a   = (signed_mode & a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign mag_b   = (signed_mode & b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign partial = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
  assign acc_sum = acc_q + partial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN);
    product   = prod_q;
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    if (accept) begin
      mcand_d  = mag_a;
      mplier_d = mag_b;
      neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_d    = '0;
      cnt_d    = '0;
    end else if (state_q == RUN) begin
      acc_d    = acc_sum;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (last) begin
        prod_d = neg_q ? (~acc_sum + 1'b1) : acc_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: tb/tb_seq_mul_radix2.sv
// Bench for seq_mul_radix2: WIDTH=4 and WIDTH=8 instances checked against an arithmetic reference multiply.
module tb_seq_mul_radix2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  a_d, b_d;
  logic        sm_d, iv, ordy;
  int          sel;

  logic        ir4, ov4, bz4, ir8, ov8, bz8;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic        iv4, iv8, or4, or8;
  logic        ir, ov, bz;
  logic [15:0] prod;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign iv4  = iv & (sel == 4);
  assign iv8  = iv & (sel == 8);
  assign or4  = ordy & (sel == 4);
  assign or8  = ordy & (sel == 8);
  assign ir   = (sel == 8) ? ir8 : ir4;
  assign ov   = (sel == 8) ? ov8 : ov4;
  assign bz   = (sel == 8) ? bz8 : bz4;
  assign prod = (sel == 8) ? p8  : {8'h00, p4};

  seq_mul_radix2 #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a_d[3:0]), .b(b_d[3:0]), .signed_mode(sm_d),
    .out_valid(ov4), .out_ready(or4), .product(p4), .busy(bz4)
  );

  seq_mul_radix2 #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a_d), .b(b_d), .signed_mode(sm_d),
    .out_valid(ov8), .out_ready(or8), .product(p8), .busy(bz8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Interpret operands as integers and multiply; keep the low 2*w bits.
  function automatic logic [15:0] ref_mul(input int w, input logic [7:0] av, input logic [7:0] bv,
                                          input logic sm);
    longint va, vb, mask;
    mask = (longint'(1) << w) - 1;
    va = longint'(av) & mask;
    vb = longint'(bv) & mask;
    if (sm && ((va >> (w - 1)) & 1) == 1) va = va - (longint'(1) << w);
    if (sm && ((vb >> (w - 1)) & 1) == 1) vb = vb - (longint'(1) << w);
    return 16'((va * vb) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic run_txn(input int w, input logic [7:0] av, input logic [7:0] bv, input logic sm,
                         input int stall, input bit churn, input logic [15:0] exp, input string tag);
    int cyc, busyc;
    sel  = w;
    a_d  = av;
    b_d  = bv;
    sm_d = sm;
    iv   = 1'b1;
    ordy = (stall == 0);
    chk({tag, " in_ready_idle"}, 64'(ir), 64'd1);
    @(posedge clk); #1;
    iv = 1'b0;
    cyc = 0;
    busyc = 0;
    while (!ov && cyc < 100) begin
      if (bz) busyc++;
      if (churn) begin
        a_d  = 8'($urandom);
        b_d  = 8'($urandom);
        sm_d = 1'($urandom);
        iv   = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(w));
    chk({tag, " busy_cycles"}, 64'(busyc), 64'(w));
    chk({tag, " product"}, 64'(prod), 64'(exp));
    for (int i = 0; i < stall; i++) begin
      if (churn) iv = 1'($urandom);
      @(posedge clk); #1;
      chk({tag, " stall_valid"}, 64'(ov), 64'd1);
      chk({tag, " stall_product"}, 64'(prod), 64'(exp));
      chk({tag, " stall_in_ready"}, 64'(ir), 64'd0);
    end
    iv   = 1'b0;
    ordy = 1'b1;
    @(posedge clk); #1;
    chk({tag, " idle_after"}, 64'(ir), 64'd1);
    chk({tag, " valid_after"}, 64'(ov), 64'd0);
    ordy = 1'b0;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sm;
    int         stall;
    bit         churn;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int cyc, last_ev, nev;
    logic [7:0]  ra, rb;
    logic        rs;

    vecs[0] = '{4'hF, 4'hF, 1'b0, 0,  1'b0, 8'hE1};
    vecs[1] = '{4'h8, 4'h8, 1'b1, 0,  1'b0, 8'h40};
    vecs[2] = '{4'h8, 4'h7, 1'b1, 0,  1'b0, 8'hC8};
    vecs[3] = '{4'hF, 4'h1, 1'b1, 0,  1'b0, 8'hFF};
    vecs[4] = '{4'hF, 4'hF, 1'b0, 10, 1'b0, 8'hE1};
    vecs[5] = '{4'hF, 4'hF, 1'b1, 3,  1'b1, 8'h01};
    vecs[6] = '{4'h0, 4'h0, 1'b1, 0,  1'b1, 8'h00};
    vecs[7] = '{4'h8, 4'hF, 1'b0, 2,  1'b1, 8'h78};
    vecs[8] = '{4'h8, 4'hF, 1'b1, 0,  1'b0, 8'h08};

    rst_n = 1'b0;
    iv    = 1'b0;
    ordy  = 1'b0;
    sm_d  = 1'b0;
    a_d   = '0;
    b_d   = '0;
    sel   = 4;
    #1;
    chk("reset in_ready4", 64'(ir4), 64'd1);
    chk("reset out_valid4", 64'(ov4), 64'd0);
    chk("reset busy4", 64'(bz4), 64'd0);
    chk("reset product4", 64'(p4), 64'd0);
    chk("reset in_ready8", 64'(ir8), 64'd1);
    chk("reset product8", 64'(p8), 64'd0);
    #11;
    rst_n = 1'b1;

    foreach (vecs[i])
      run_txn(4, {4'h0, vecs[i].a}, {4'h0, vecs[i].b}, vecs[i].sm, vecs[i].stall, vecs[i].churn,
              {8'h00, vecs[i].exp}, $sformatf("vec%0d", i));

    // Back-to-back: in_valid and out_ready held high, 5*6 repeatedly.
    sel  = 4;
    a_d  = 8'd5;
    b_d  = 8'd6;
    sm_d = 1'b0;
    iv   = 1'b1;
    ordy = 1'b1;
    cyc = 0;
    nev = 0;
    last_ev = 0;
    while (nev < 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (ov) begin
        chk("b2b product", 64'(prod), 64'h1E);
        if (nev > 0) chk("b2b interval", 64'(cyc - last_ev), 64'd6);
        last_ev = cyc;
        nev++;
      end
    end
    iv = 1'b0;
    chk("b2b events", 64'(nev), 64'd3);
    @(posedge clk); #1;
    ordy = 1'b0;
    chk("b2b idle", 64'(ir), 64'd1);

    // Reset two cycles into RUN.
    a_d = 8'd7;
    b_d = 8'd7;
    iv  = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    @(posedge clk); #1;
    chk("midrst busy_before", 64'(bz), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", 64'(ir), 64'd1);
    chk("midrst out_valid", 64'(ov), 64'd0);
    chk("midrst busy", 64'(bz), 64'd0);
    chk("midrst product", 64'(prod), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn(4, 8'd3, 8'd5, 1'b0, 0, 1'b0, 16'h000F, "post_reset");

    for (int i = 0; i < 80; i++) begin
      int w;
      w  = (i < 40) ? 4 : 8;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      if (w == 4) begin
        ra[7:4] = '0;
        rb[7:4] = '0;
      end
      run_txn(w, ra, rb, rs, $urandom_range(0, 3), 1'($urandom), ref_mul(w, ra, rb, rs),
              $sformatf("rnd%0d w%0d %0h*%0h s%0b", i, w, ra, rb, rs));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
